// File: rtl/fmps_multi_read_link.sv
// rtl/fmps_multi_read_link.sv - multi-link FMPS packet receiver; FMPS_READ_LINK_DUP_REJECT_EN rejects duplicate indices
module fmps_multi_read_link #(
    parameter int                     NUM_LINKS       = 2,
    parameter int                     INDEX_WIDTH     = 5,
    parameter int                     MAGIC_WIDTH     = 16,
    parameter int                     MAGIC_START_BIT = 16,
    parameter int                     INDEX_START_BIT = 10,
    parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC    = 16'hB6CF,
    localparam int                    LINK_W          = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1,
    localparam int                    DEPTH           = 1 << INDEX_WIDTH,
    localparam int                    CNT_W           = INDEX_WIDTH + 1
) (
    input  logic                     auroraClk,
    input  logic                     auroraReset_n,
    input  logic                     FAstrobe,
    input  logic [CNT_W-1:0]         expectedCount,
    input  logic [NUM_LINKS-1:0]     TVALID,
    input  logic [NUM_LINKS-1:0]     TLAST,
    input  logic [32*NUM_LINKS-1:0]  TDATA,
    output logic                     statusStrobe,
    output logic [1:0]               statusCode,
    output logic [DEPTH-1:0]         fmpsBitmap,
    output logic [CNT_W-1:0]         fmpsCounter,
    input  logic [INDEX_WIDTH-1:0]   readoutAddress,
    output logic [31:0]              readoutFMPS,
    output logic [LINK_W-1:0]        readoutLink
);

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_DATA    = 2'd1,
        ST_DISCARD = 2'd2
    } parse_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [NUM_LINKS-1:0]   w_hold_full;
    logic [NUM_LINKS-1:0]   w_link_err;
    logic [NUM_LINKS-1:0]   w_link_ovr;
    logic [NUM_LINKS-1:0]   w_gnt;
    logic [INDEX_WIDTH-1:0] w_hold_idx  [NUM_LINKS];
    logic [31:0]            w_hold_data [NUM_LINKS];

    for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
        parse_state_t           r_state;
        parse_state_t           w_state_nxt;
        logic [INDEX_WIDTH-1:0] r_pkt_idx;
        logic                   r_full;
        logic [INDEX_WIDTH-1:0] r_idx;
        logic [31:0]            r_data;
        logic [31:0]            w_beat;
        logic                   w_magic_ok;
        logic                   w_complete;
        logic                   w_err;
        logic                   w_latch;
        logic                   w_load;

        assign w_beat     = TDATA[32*k +: 32];
        assign w_magic_ok = (w_beat[MAGIC_START_BIT +: MAGIC_WIDTH] == HEADER_MAGIC);

        always_comb begin
            w_state_nxt = r_state;
            w_complete  = 1'b0;
            w_err       = 1'b0;
            w_latch     = 1'b0;
            if (TVALID[k]) begin
                case (r_state)
                    ST_HEADER: begin
                        if (TLAST[k]) begin
                            w_err = 1'b1;
                        end else if (w_magic_ok) begin
                            w_latch     = 1'b1;
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                    ST_DATA: begin
                        if (TLAST[k]) begin
                            w_complete  = 1'b1;
                            w_state_nxt = ST_HEADER;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (TLAST[k]) begin
                            w_state_nxt = ST_HEADER;
                        end
                    end
                    default: w_state_nxt = ST_HEADER;
                endcase
            end
        end

        // A holding register being granted this cycle can take the next packet on the same edge.
        assign w_load = w_complete && (!r_full || w_gnt[k]);

        always_ff @(posedge auroraClk) begin
            if (!auroraReset_n) begin
                r_state <= ST_HEADER;
                r_full  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_load) begin
                    r_full <= 1'b1;
                end else if (w_gnt[k]) begin
                    r_full <= 1'b0;
                end
            end
        end

        always_ff @(posedge auroraClk) begin
            if (w_latch) begin
                r_pkt_idx <= w_beat[INDEX_START_BIT +: INDEX_WIDTH];
            end
            if (w_load) begin
                r_idx  <= r_pkt_idx;
                r_data <= w_beat;
            end
        end

        assign w_hold_full[k] = r_full;
        assign w_link_err[k]  = w_err;
        assign w_link_ovr[k]  = w_complete && r_full && !w_gnt[k];
        assign w_hold_idx[k]  = r_idx;
        assign w_hold_data[k] = r_data;
    end

    logic [LINK_W-1:0]      r_rr_ptr;
    logic                   w_gnt_vld;
    logic [LINK_W-1:0]      w_gnt_link;
    logic [INDEX_WIDTH-1:0] w_gnt_idx;
    logic [31:0]            w_gnt_data;
    logic [LINK_W-1:0]      w_j;

    // Round-robin search starts at the link after the last grant.
    always_comb begin
        int j;
        j          = 0;
        w_j        = '0;
        w_gnt      = '0;
        w_gnt_vld  = 1'b0;
        w_gnt_link = '0;
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            j = int'(r_rr_ptr) + i;
            if (j >= NUM_LINKS) begin
                j = j - NUM_LINKS;
            end
            w_j = LINK_W'(j);
            if (!w_gnt_vld && w_hold_full[w_j]) begin
                w_gnt_vld    = 1'b1;
                w_gnt[w_j]   = 1'b1;
                w_gnt_link   = w_j;
                w_gnt_idx    = w_hold_idx[w_j];
                w_gnt_data   = w_hold_data[w_j];
            end
        end
    end

    logic [DEPTH-1:0] r_bitmap;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic             r_ovr;
    logic             r_status_strobe;
    logic [1:0]       r_status_code;
    logic [DEPTH-1:0] w_bitmap_base;
    logic [CNT_W-1:0] w_count_base;
    logic [DEPTH-1:0] w_onehot;
    logic             w_bit_was_set;
    logic             w_dup_err;
    logic             w_write;
    logic             w_err_evt;
    logic             w_ovr_evt;

    // On the strobe cycle everything accounted this cycle starts from an empty slate.
    assign w_bitmap_base = FAstrobe ? '0 : r_bitmap;
    assign w_count_base  = FAstrobe ? '0 : r_count;
    assign w_onehot      = {{(DEPTH-1){1'b0}}, 1'b1} << w_gnt_idx;
    assign w_bit_was_set = w_bitmap_base[w_gnt_idx];

`ifdef FMPS_READ_LINK_DUP_REJECT_EN
    assign w_dup_err = w_gnt_vld && w_bit_was_set;
`else
    assign w_dup_err = 1'b0;
`endif

    assign w_write   = auroraReset_n && w_gnt_vld && !w_dup_err;
    assign w_err_evt = (|w_link_err) || w_dup_err;
    assign w_ovr_evt = |w_link_ovr;

    always_ff @(posedge auroraClk) begin
        if (!auroraReset_n) begin
            r_bitmap        <= '0;
            r_count         <= '0;
            r_err           <= 1'b0;
            r_ovr           <= 1'b0;
            r_rr_ptr        <= '0;
            r_status_strobe <= 1'b0;
            r_status_code   <= 2'd0;
        end else begin
            r_status_strobe <= FAstrobe;
            if (FAstrobe) begin
                r_status_code <= r_ovr ? 2'd3 :
                                 r_err ? 2'd2 :
                                 (r_count < expectedCount) ? 2'd1 : 2'd0;
            end
            r_err <= (FAstrobe ? 1'b0 : r_err) | w_err_evt;
            r_ovr <= (FAstrobe ? 1'b0 : r_ovr) | w_ovr_evt;
            if (w_write) begin
                r_bitmap <= w_bitmap_base | w_onehot;
                if (!w_bit_was_set && (w_count_base != CNT_MAX)) begin
                    r_count <= w_count_base + CNT_W'(1);
                end else begin
                    r_count <= w_count_base;
                end
            end else begin
                r_bitmap <= w_bitmap_base;
                r_count  <= w_count_base;
            end
            if (w_gnt_vld) begin
                r_rr_ptr <= (w_gnt_link == LINK_W'(NUM_LINKS - 1)) ? '0 : w_gnt_link + LINK_W'(1);
            end
        end
    end

    logic [31:0]       r_ram      [DEPTH];
    logic [LINK_W-1:0] r_ram_link [DEPTH];
    logic [31:0]       r_rd_data;
    logic [LINK_W-1:0] r_rd_link;

    always_ff @(posedge auroraClk) begin
        if (w_write) begin
            r_ram[w_gnt_idx]      <= w_gnt_data;
            r_ram_link[w_gnt_idx] <= w_gnt_link;
        end
    end

    always_ff @(posedge auroraClk) begin
        if (!auroraReset_n) begin
            r_rd_data <= '0;
            r_rd_link <= '0;
        end else begin
            r_rd_data <= r_ram[readoutAddress];
            r_rd_link <= r_ram_link[readoutAddress];
        end
    end

    assign statusStrobe = r_status_strobe;
    assign statusCode   = r_status_code;
    assign fmpsBitmap   = r_bitmap;
    assign fmpsCounter  = r_count;
    assign readoutFMPS  = r_rd_data;
    assign readoutLink  = r_rd_link;

endmodule

// File: tb/tb_fmps_multi_read_link.sv
// tb/tb_fmps_multi_read_link.sv - directed bench for fmps_multi_read_link with a packet-level model
module tb_fmps_multi_read_link;
    localparam int NL    = 3;
    localparam int IW    = 5;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic              clk = 1'b0;
    logic              resetn;
    logic              FAstrobe;
    logic [CW-1:0]     expectedCount;
    logic [NL-1:0]     TVALID;
    logic [NL-1:0]     TLAST;
    logic [32*NL-1:0]  TDATA;
    logic              statusStrobe;
    logic [1:0]        statusCode;
    logic [DEPTH-1:0]  fmpsBitmap;
    logic [CW-1:0]     fmpsCounter;
    logic [IW-1:0]     readoutAddress;
    logic [IW-1:0]     addr_q;
    logic [31:0]       readoutFMPS;
    logic [1:0]        readoutLink;

    always #5 clk = ~clk;

    fmps_multi_read_link #(.NUM_LINKS(NL)) dut (
        .auroraClk      (clk),
        .auroraReset_n  (resetn),
        .FAstrobe       (FAstrobe),
        .expectedCount  (expectedCount),
        .TVALID         (TVALID),
        .TLAST          (TLAST),
        .TDATA          (TDATA),
        .statusStrobe   (statusStrobe),
        .statusCode     (statusCode),
        .fmpsBitmap     (fmpsBitmap),
        .fmpsCounter    (fmpsCounter),
        .readoutAddress (readoutAddress),
        .readoutFMPS    (readoutFMPS),
        .readoutLink    (readoutLink)
    );

    // Packet-level model: which indices arrived this cycle, sticky flags, and what the RAM should hold.
    logic [DEPTH-1:0] m_bitmap;
    bit               m_err;
    bit               m_ovr;
    logic [31:0]      m_ram   [DEPTH];
    logic [1:0]       m_link  [DEPTH];
    bit               m_known [DEPTH];
    bit               m_settled;
    bit               chk_en;
    bit               exp_strobe;
    logic [1:0]       exp_code;
    bit               addr_hold;
    int               n_pass;
    int               n_checks;
    logic [1:0]       code;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] hdr(input int idx);
        return 32'hB6CF_0000 | (32'(idx) << 10);
    endfunction

    function automatic logic [1:0] m_status();
        if (m_ovr) return 2'd3;
        if (m_err) return 2'd2;
        if ($countones(m_bitmap) < int'(expectedCount)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic m_add(input int idx, input logic [31:0] d, input int l);
`ifdef FMPS_READ_LINK_DUP_REJECT_EN
        if (m_bitmap[idx]) begin
            m_err = 1'b1;
            return;
        end
`endif
        m_bitmap[idx] = 1'b1;
        m_ram[idx]    = d;
        m_link[idx]   = 2'(l);
        m_known[idx]  = 1'b1;
    endtask

    task automatic m_clear();
        m_bitmap = '0;
        m_err    = 1'b0;
        m_ovr    = 1'b0;
    endtask

    always @(posedge clk) addr_q <= readoutAddress;

    always @(negedge clk) begin
        if (chk_en) begin
            check("strobe", {63'd0, statusStrobe}, {63'd0, exp_strobe});
            if (exp_strobe) check("model code", {62'd0, statusCode}, {62'd0, exp_code});
            if (m_settled) begin
                check("model bitmap", {32'd0, fmpsBitmap}, {32'd0, m_bitmap});
                check("model counter", {58'd0, fmpsCounter}, 64'($countones(m_bitmap)));
                if (m_known[addr_q]) begin
                    check("model readout data", {32'd0, readoutFMPS}, {32'd0, m_ram[addr_q]});
                    check("model readout link", {62'd0, readoutLink}, {62'd0, m_link[addr_q]});
                end
            end
        end
    end

    initial begin
        readoutAddress = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!addr_hold) readoutAddress = readoutAddress + 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_beats();
        TVALID = '0;
        TLAST  = '0;
        TDATA  = '0;
    endtask

    task automatic set_beat(input int l, input logic last, input logic [31:0] d);
        TVALID[l]         = 1'b1;
        TLAST[l]          = last;
        TDATA[32*l +: 32] = d;
    endtask

    task automatic send_pkt(input int l, input int idx, input logic [31:0] d);
        m_settled = 1'b0;
        set_beat(l, 1'b0, hdr(idx));
        tick();
        clr_beats();
        set_beat(l, 1'b1, d);
        tick();
        clr_beats();
        tick();
        tick();
        m_add(idx, d, l);
        m_settled = 1'b1;
    endtask

    task automatic do_strobe(output logic [1:0] got);
        FAstrobe = 1'b1;
        tick();
        FAstrobe   = 1'b0;
        got        = statusCode;
        exp_code   = m_status();
        exp_strobe = 1'b1;
        m_clear();
        tick();
        exp_strobe = 1'b0;
    endtask

    task automatic read_at(input int a, input logic [31:0] d, input logic [1:0] l, input string name);
        addr_hold      = 1'b1;
        readoutAddress = IW'(a);
        tick();
        check({name, " data"}, {32'd0, readoutFMPS}, {32'd0, d});
        check({name, " link"}, {62'd0, readoutLink}, {62'd0, l});
        addr_hold = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " strobe"}, {63'd0, statusStrobe}, 64'd0);
        check({name, " code"}, {62'd0, statusCode}, 64'd0);
        check({name, " bitmap"}, {32'd0, fmpsBitmap}, 64'd0);
        check({name, " counter"}, {58'd0, fmpsCounter}, 64'd0);
        check({name, " readout"}, {32'd0, readoutFMPS}, 64'd0);
        check({name, " link"}, {62'd0, readoutLink}, 64'd0);
    endtask

    initial begin
        n_pass = 0; n_checks = 0;
        resetn = 1'b0; FAstrobe = 1'b0; expectedCount = '0;
        addr_hold = 1'b0; m_settled = 1'b0; chk_en = 1'b0; exp_strobe = 1'b0; exp_code = 2'd0;
        clr_beats();
        m_clear();
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check_all_zero("reset");
        resetn = 1'b1;
        tick();
        tick();
        m_settled = 1'b1;

        // Single link, 12 packets
        expectedCount = 6'd12;
        for (int i = 0; i < 12; i++) send_pkt(0, i, 32'h00CACA00 | (32'(i) << 24));
        check("t1 bitmap", {32'd0, fmpsBitmap}, 64'h0000_0FFF);
        check("t1 counter", {58'd0, fmpsCounter}, 64'd12);
        read_at(5, 32'h05CACA00, 2'd0, "t1 addr5");
        do_strobe(code);
        check("t1 code", {62'd0, code}, 64'd0);

        // Two links complete on the same edge
        expectedCount = 6'd2;
        m_settled = 1'b0;
        set_beat(0, 1'b0, hdr(3));
        set_beat(1, 1'b0, hdr(4));
        tick();
        set_beat(0, 1'b1, 32'hA000_0003);
        set_beat(1, 1'b1, 32'hB000_0004);
        tick();
        clr_beats();
        tick(); tick(); tick();
        m_add(3, 32'hA000_0003, 0);
        m_add(4, 32'hB000_0004, 1);
        m_settled = 1'b1;
        check("t2 counter", {58'd0, fmpsCounter}, 64'd2);
        read_at(3, 32'hA000_0003, 2'd0, "t2 addr3");
        read_at(4, 32'hB000_0004, 2'd1, "t2 addr4");
        do_strobe(code);
        check("t2 code", {62'd0, code}, 64'd0);

        // Bad magic, then header carrying TLAST
        expectedCount = 6'd0;
        m_settled = 1'b0;
        set_beat(0, 1'b0, 32'hB6CE_1800);
        tick();
        set_beat(0, 1'b1, 32'h1234_5678);
        tick();
        clr_beats();
        tick(); tick();
        m_err = 1'b1;
        m_settled = 1'b1;
        check("t3 counter", {58'd0, fmpsCounter}, 64'd0);
        do_strobe(code);
        check("t3 badmagic code", {62'd0, code}, 64'd2);
        set_beat(1, 1'b1, hdr(5));
        tick();
        clr_beats();
        tick();
        m_err = 1'b1;
        do_strobe(code);
        check("t3 hdrlast code", {62'd0, code}, 64'd2);

        // Missing one of twelve
        expectedCount = 6'd12;
        for (int i = 0; i < 11; i++) send_pkt(1, i, 32'h1100_0000 | 32'(i));
        check("t4 counter", {58'd0, fmpsCounter}, 64'd11);
        do_strobe(code);
        check("t4 code", {62'd0, code}, 64'd1);

        // All three links back-to-back 2-beat packets
        expectedCount = 6'd0;
        m_settled = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < NL; k++) begin
                if (c % 2 == 0) set_beat(k, 1'b0, hdr(k * 4 + c / 2));
                else set_beat(k, 1'b1, 32'hC000_0000 | 32'(k * 4 + c / 2));
            end
            tick();
        end
        clr_beats();
        tick(); tick(); tick(); tick();
        m_ovr = 1'b1;
        for (int i = 0; i < 12; i++) m_known[i] = 1'b0;
        do_strobe(code);
        check("t5 code", {62'd0, code}, 64'd3);
        m_settled = 1'b1;

        // Duplicate index 7
        expectedCount = 6'd1;
        send_pkt(0, 7, 32'hD1D1_0007);
        send_pkt(1, 7, 32'hD2D2_0007);
        check("t6 counter", {58'd0, fmpsCounter}, 64'd1);
`ifdef FMPS_READ_LINK_DUP_REJECT_EN
        read_at(7, 32'hD1D1_0007, 2'd0, "t6 addr7");
        do_strobe(code);
        check("t6 code", {62'd0, code}, 64'd2);
`else
        read_at(7, 32'hD2D2_0007, 2'd1, "t6 addr7");
        do_strobe(code);
        check("t6 code", {62'd0, code}, 64'd0);
`endif

        // RAM write and an error event coincide with FAstrobe
        expectedCount = 6'd3;
        send_pkt(2, 1, 32'hE000_0001);
        send_pkt(2, 2, 32'hE000_0002);
        m_settled = 1'b0;
        set_beat(0, 1'b0, hdr(9));
        tick();
        set_beat(0, 1'b1, 32'hE000_0009);
        tick();
        clr_beats();
        FAstrobe = 1'b1;
        set_beat(1, 1'b1, hdr(12));
        tick();
        FAstrobe = 1'b0;
        clr_beats();
        code       = statusCode;
        exp_code   = m_status();
        exp_strobe = 1'b1;
        m_clear();
        m_add(9, 32'hE000_0009, 0);
        m_err = 1'b1;
        tick();
        exp_strobe = 1'b0;
        m_settled  = 1'b1;
        check("t7 code", {62'd0, code}, 64'd1);
        check("t7 counter", {58'd0, fmpsCounter}, 64'd1);
        check("t7 bitmap", {32'd0, fmpsBitmap}, 64'h0000_0200);
        expectedCount = 6'd1;
        do_strobe(code);
        check("t7 next code", {62'd0, code}, 64'd2);

        // Reset in the middle of a packet
        m_settled = 1'b0;
        set_beat(0, 1'b0, hdr(2));
        tick();
        clr_beats();
        resetn = 1'b0;
        tick();
        tick();
        check_all_zero("t8 reset");
        m_clear();
        resetn = 1'b1;
        tick();
        send_pkt(0, 2, 32'hF000_0002);
        check("t8 counter", {58'd0, fmpsCounter}, 64'd1);
        read_at(2, 32'hF000_0002, 2'd0, "t8 addr2");
        do_strobe(code);
        check("t8 code", {62'd0, code}, 64'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
